// File: rtl/load_store_unit_pkg.sv
// Shared load/store definitions: FSM states, access size codes and the
// big-endian lane extract/merge helpers used by the LSU and the decoder.
package load_store_unit_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_RMW_RD, ST_WR, ST_RESP} lsu_state_e;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} lsu_size_e;

  typedef struct packed {
    lsu_size_e size;
    logic      sign_ext;
  } lsu_ctl_t;

  // Big-endian: offset 0 is the top byte, so the lane shift counts down from the MSB.
  function automatic logic [4:0] lane_shift(lsu_size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: return {~off, 3'b000};
      SZ_HALF: return {~off[1], 4'b0000};
      default: return 5'd0;
    endcase
  endfunction

  function automatic word_t lane_extract(word_t word, lsu_size_e size, logic [1:0] off, logic sext);
    word_t sh;
    sh = word >> lane_shift(size, off);
    case (size)
      SZ_BYTE: return {{24{sext & sh[7]}}, sh[7:0]};
      SZ_HALF: return {{16{sext & sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic word_t lane_merge(word_t word, word_t wdata, lsu_size_e size, logic [1:0] off);
    word_t mask;
    case (size)
      SZ_BYTE: mask = 32'h0000_00FF;
      SZ_HALF: mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << lane_shift(size, off);
    return (word & ~mask) | ((wdata << lane_shift(size, off)) & mask);
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake plus the word-wide data memory bus.
interface load_store_unit_if #(parameter int n = 32);
  logic         req_valid, req_ready, req_write, req_sign_ext;
  logic [1:0]   req_size;
  logic [n-1:0] req_addr, req_wdata;
  logic         resp_valid, resp_error, stall;
  logic [n-1:0] resp_rdata;
  logic [n-1:0] mem_address, mem_write_data, mem_data_out;
  logic         mem_read, mem_write_in, mem_ready;

  modport master (
    output req_valid, req_write, req_size, req_sign_ext, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error, stall,
    input  mem_address, mem_read, mem_write_in, mem_write_data,
    output mem_data_out, mem_ready
  );

  modport slave (
    input  req_valid, req_write, req_size, req_sign_ext, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error, stall,
    output mem_address, mem_read, mem_write_in, mem_write_data,
    input  mem_data_out, mem_ready
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane extract/extend for loads and byte/halfword merge for stores.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  word_t      rdata,
  input  word_t      wdata,
  input  lsu_size_e  size,
  input  logic [1:0] offset,
  input  logic       sign_ext,
  output word_t      load_data,
  output word_t      merged
);
  assign load_data = lane_extract(rdata, size, offset, sign_ext);
  assign merged    = lane_merge(rdata, wdata, size, offset);
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: word-wide memory, sub-word stores done
// as read-modify-write, errors answered without touching memory.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int n         = 32,
  parameter int MEM_BYTES = 1024
) (
  input logic               clk,
  input logic               reset_n,
  load_store_unit_if.slave  bus
);
  localparam int NW = n + 1;

  lsu_state_e   state, state_nx;
  lsu_ctl_t     ctl;
  logic [n-1:0] addr_q, wdata_q, rdata_q;
  logic         err_q;
  logic         accept, req_err, rd_act, wr_act;
  logic [n:0]   word_end;
  lsu_size_e    req_size_e;
  word_t        load_data, merged;

  assign req_size_e = lsu_size_e'(bus.req_size);
  assign accept     = bus.req_valid && (state == ST_IDLE);

  // Range check in n+1 bits so addresses near the top cannot wrap past the limit.
  assign word_end = {1'b0, bus.req_addr[n-1:2], 2'b00} + NW'(3);
  assign req_err  = (req_size_e == SZ_ILL)
                 || (req_size_e == SZ_HALF && bus.req_addr[0])
                 || (req_size_e == SZ_WORD && bus.req_addr[1:0] != 2'b00)
                 || (word_end >= NW'(MEM_BYTES));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) begin
        if (req_err)                   state_nx = ST_RESP;
        else if (!bus.req_write)       state_nx = ST_RD;
        else if (req_size_e == SZ_WORD) state_nx = ST_WR;
        else                           state_nx = ST_RMW_RD;
      end
      ST_RD:     if (bus.mem_ready) state_nx = ST_RESP;
      ST_RMW_RD: if (bus.mem_ready) state_nx = ST_WR;
      ST_WR:     if (bus.mem_ready) state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      ctl     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ctl.size     <= req_size_e;
        ctl.sign_ext <= bus.req_sign_ext;
        addr_q       <= bus.req_addr;
        wdata_q      <= bus.req_wdata;
        err_q        <= req_err;
        rdata_q      <= '0;
      end
      if (state == ST_RD && bus.mem_ready)     rdata_q <= load_data;
      // The merged word replaces the store data so WR drives it unchanged.
      if (state == ST_RMW_RD && bus.mem_ready) wdata_q <= merged;
    end
  end

  lsu_lane_align u_align (
    .rdata     (bus.mem_data_out),
    .wdata     (wdata_q),
    .size      (ctl.size),
    .offset    (addr_q[1:0]),
    .sign_ext  (ctl.sign_ext),
    .load_data (load_data),
    .merged    (merged)
  );

  // All outputs decode from state so reset clears them without waiting for a clock.
  assign rd_act             = (state == ST_RD) || (state == ST_RMW_RD);
  assign wr_act             = (state == ST_WR);
  assign bus.req_ready      = (state == ST_IDLE);
  assign bus.stall          = (state != ST_IDLE);
  assign bus.mem_read       = rd_act;
  assign bus.mem_write_in   = wr_act;
  assign bus.mem_address    = (rd_act || wr_act) ? {addr_q[n-1:2], 2'b00} : '0;
  assign bus.mem_write_data = wr_act ? wdata_q : '0;
  assign bus.resp_valid     = (state == ST_RESP);
  assign bus.resp_rdata     = (state == ST_RESP) ? rdata_q : '0;
  assign bus.resp_error     = (state == ST_RESP) && err_q;
endmodule
